// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI frame sequencer and its benches.
package spi_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int CLK_DIV_DEF = 4;

    // Interval counter terminal count (65000) marking the end of the interframe gap.
    localparam logic [15:0] GAP_TICKS = 16'hFDE8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: ticks every CLK_DIV clks while run is high, toggles sclk on ticks when toggle is high.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic toggle,
    output logic sclk,
    output logic tick,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick       = run && (cnt == TERM);
    assign rise_pulse = tick && toggle && !sclk;
    assign fall_pulse = tick && toggle && sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            if (toggle)
                sclk <= !sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_frame_sequencer.sv
// SPI master (CPOL=0, CPHA=0, MSB first) that paces frames with an external interframe interval counter.
module spi_frame_sequencer
    import spi_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    input  logic              tiempo,
    input  logic              tx_done,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              ready
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state, state_nx;
    logic [DATA_W-1:0] tx_shift, rx_shift, launch_word;
    logic [BW-1:0]     bit_cnt;
    logic              pending, gap_open, pending_nx, gap_open_nx;
    logic              tick, rise_pulse, fall_pulse, run, toggle;
    logic              take_new, launch, last_fall, hold_exit;
    logic              cs_n_nx, mosi_nx, cnt_en_nx, cnt_clr_nx, rx_valid_nx, busy_nx, ready_nx;

    assign run       = (state == LOAD) || (state == SHIFT) || (state == HOLD);
    assign toggle    = (state == SHIFT);
    assign last_fall = (state == SHIFT) && fall_pulse && (bit_cnt == LAST_BIT);
    assign hold_exit = (state == HOLD) && tick;

    // A word is taken from tx_data either from IDLE or as the single pending word in GAP.
    assign take_new    = ((state == IDLE) && start) ||
                         ((state == GAP) && ready && start && !pending);
    assign launch      = (state_nx == LOAD) && (state != LOAD);
    assign launch_word = ((state == GAP) && pending) ? tx_shift : tx_data;

    assign pending_nx  = (state == GAP) && !tiempo && (pending || take_new);
    assign gap_open_nx = (state == GAP) && !tiempo && (gap_open || tx_done);

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .toggle     (toggle),
        .sclk       (sclk),
        .tick       (tick),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (tick) state_nx = SHIFT;
            SHIFT:   if (last_fall) state_nx = HOLD;
            HOLD:    if (tick) state_nx = GAP;
            GAP:     if (tiempo) state_nx = (pending || take_new) ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cs_n_nx     = cs_n;
        mosi_nx     = mosi;
        cnt_clr_nx  = 1'b0;
        rx_valid_nx = 1'b0;
        cnt_en_nx   = (state_nx == GAP);
        busy_nx     = (state_nx != IDLE);
        ready_nx    = 1'b0;
        if (launch) begin
            cs_n_nx    = 1'b0;
            mosi_nx    = launch_word[DATA_W-1];
            cnt_clr_nx = 1'b1;
        end else if ((state == SHIFT) && fall_pulse && !last_fall) begin
            mosi_nx = tx_shift[DATA_W-2];
        end else if (hold_exit) begin
            cs_n_nx     = 1'b1;
            mosi_nx     = 1'b0;
            rx_valid_nx = 1'b1;
        end
        if (state_nx == IDLE)
            ready_nx = 1'b1;
        else if (state_nx == GAP)
            ready_nx = gap_open_nx && !pending_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b1;
            rx_data  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            pending  <= 1'b0;
            gap_open <= 1'b0;
        end else begin
            cs_n     <= cs_n_nx;
            mosi     <= mosi_nx;
            cnt_en   <= cnt_en_nx;
            cnt_clr  <= cnt_clr_nx;
            rx_valid <= rx_valid_nx;
            busy     <= busy_nx;
            ready    <= ready_nx;
            pending  <= pending_nx;
            gap_open <= gap_open_nx;
            if (take_new)
                tx_shift <= tx_data;
            else if ((state == SHIFT) && fall_pulse)
                tx_shift <= tx_shift << 1;
            if (launch)
                rx_shift <= '0;
            else if (rise_pulse)
                rx_shift <= {rx_shift[DATA_W-2:0], miso};
            // Bit counter saturates on the last bit; it is only restarted by a new launch.
            if (launch)
                bit_cnt <= '0;
            else if ((state == SHIFT) && fall_pulse && !last_fall)
                bit_cnt <= bit_cnt + 1'b1;
            if (hold_exit)
                rx_data <= rx_shift;
        end
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Bench for spi_frame_sequencer: interval counter model, SPI slave model, frame monitor, table + random frames.
module tb_spi_frame_sequencer;

    localparam int DW = 16;
    localparam int CD = 4;
    localparam int FRAME_CLKS = (2*DW + 2) * CD;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          miso, tiempo, tx_done;
    logic          cnt_en, cnt_clr, sclk, mosi, cs_n, rx_valid, busy, ready;
    logic [DW-1:0] rx_data;

    always #5 clk = ~clk;

    spi_frame_sequencer #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .miso(miso),
        .tiempo(tiempo), .tx_done(tx_done), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .ready(ready)
    );

    // Interval counter: negedge clocked, cleared by cnt_clr or rst, saturates at term.
    int unsigned term = 40;
    int unsigned gcnt = 0;
    logic ovr = 1'b0, ovr_tm = 1'b0, ovr_td = 1'b0;
    always @(negedge clk or posedge rst)
        if (rst)                          gcnt <= 0;
        else if (cnt_clr)                 gcnt <= 0;
        else if (cnt_en && gcnt < term)   gcnt <= gcnt + 1;
    assign tiempo  = ovr ? ovr_tm : (gcnt == term);
    assign tx_done = ovr ? ovr_td : (gcnt == term - 1);

    // Frame monitor; also steps the slave's MSB-first bit pointer on every SCLK fall.
    int            f_cs_len = 0, f_rises = 0, f_falls = 0, f_rxv = 0, f_clr = 0, sbit = DW-1;
    logic [DW-1:0] f_mosi = '0, f_rx = '0;
    logic          f_many = 1'b0, prev_sclk = 1'b0, prev_cs = 1'b1;
    logic          loop = 1'b1;
    logic [DW-1:0] slave_word = '0;
    assign miso = loop ? mosi : slave_word[sbit];

    always @(negedge clk) begin
        if (prev_cs && !cs_n) begin
            f_cs_len = 0; f_rises = 0; f_falls = 0; f_rxv = 0; f_clr = 0;
            f_mosi = '0; f_many = 1'b0; sbit = DW-1;
        end
        if (!cs_n) begin
            f_cs_len++;
            f_many = f_many | mosi;
        end
        if (!prev_sclk && sclk && !cs_n) begin
            f_rises++;
            f_mosi = {f_mosi[DW-2:0], mosi};
        end
        if (prev_sclk && !sclk && !cs_n) begin
            f_falls++;
            if (sbit > 0) sbit--;
        end
        if (rx_valid) begin
            f_rxv++;
            f_rx = rx_data;
        end
        if (cnt_clr) f_clr++;
        prev_sclk = sclk;
        prev_cs   = cs_n;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int bound);
        int t = 0;
        while (busy && t < bound) begin tick_n(1); t++; end
        chk("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_rxv();
        int t = 0;
        while (!rx_valid && t < 400) begin tick_n(1); t++; end
        chk("rx_valid_seen", {31'd0, rx_valid}, 32'd1);
    endtask

    // One frame from IDLE through its whole gap, checked against the protocol rules.
    task automatic run_frame(input logic [DW-1:0] w, input logic lp,
                             input logic [DW-1:0] sw, input logic [DW-1:0] exp_rx);
        int   gl, t;
        logic en_bad;
        loop = lp; slave_word = sw;
        wait_idle(70000);
        tx_data = w; start = 1'b1;
        tick_n(1);
        start = 1'b0;
        chk("launch_cs_clr_busy", {29'd0, cs_n, cnt_clr, busy}, 32'b011);
        wait_rxv();
        chk("cs_low_clks", f_cs_len, FRAME_CLKS);
        chk("sclk_rises", f_rises, DW);
        chk("mosi_word", {16'd0, f_mosi}, {16'd0, w});
        chk("mosi_any_one", {31'd0, f_many}, {31'd0, (w != '0)});
        chk("rx_data", {16'd0, f_rx}, {16'd0, exp_rx});
        gl = 1; en_bad = !cnt_en; t = 0;
        while (t < 70000) begin
            tick_n(1); t++;
            if (!busy) break;
            gl++;
            if (!cnt_en || !cs_n) en_bad = 1'b1;
        end
        chk("gap_clks", gl, term);
        chk("gap_cnt_en_cs", {31'd0, en_bad}, 32'd0);
        chk("after_gap_en_rdy_busy", {29'd0, cnt_en, ready, busy}, 32'b010);
        chk("rx_valid_count", f_rxv, 1);
        chk("cnt_clr_count", f_clr, 1);
    endtask

    typedef struct {
        logic [DW-1:0] tx;
        logic          lp;
        logic [DW-1:0] sw;
        logic [DW-1:0] exp_rx;
    } vec_t;
    vec_t tbl [5];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, falls, first_fall, second_fall, rxv_cnt;
        logic pcs;
        logic [DW-1:0] w, sw;
        logic lp;

        tbl[0] = '{16'hA5C3, 1'b1, 16'h0000, 16'hA5C3};
        tbl[1] = '{16'h0000, 1'b0, 16'hFFFF, 16'hFFFF};
        tbl[2] = '{16'hFFFF, 1'b0, 16'h0000, 16'h0000};
        tbl[3] = '{16'h8001, 1'b0, 16'h5AA5, 16'h5AA5};
        tbl[4] = '{16'h1234, 1'b1, 16'h0000, 16'h1234};

        tick_n(2);
        chk("in_reset_outputs", {24'd0, cs_n, sclk, mosi, cnt_en, cnt_clr, rx_valid, busy, ready},
            32'b1000_0001);
        rst = 1'b0;
        tick_n(2);
        chk("post_reset_outputs", {24'd0, cs_n, sclk, mosi, cnt_en, cnt_clr, rx_valid, busy, ready},
            32'b1000_0001);
        chk("post_reset_rx_data", {16'd0, rx_data}, 32'd0);

        // Table frames; the first uses the full-length interval.
        for (int i = 0; i < 5; i++) begin
            term = (i == 0) ? 32'(spi_pkg::GAP_TICKS) : 40;
            run_frame(tbl[i].tx, tbl[i].lp, tbl[i].sw, tbl[i].exp_rx);
        end

        // Early start: ignored before tx_done, accepted afterwards, launches right after tiempo.
        term = 40; loop = 1'b1;
        tx_data = 16'h5555; start = 1'b1; tick_n(1); start = 1'b0;
        wait_rxv();
        tx_data = 16'h1234; start = 1'b1; tick_n(1); start = 1'b0;
        chk("early_start_ignored", {30'd0, ready, cs_n}, 32'b01);
        t = 0;
        while (!ready && t < 100) begin tick_n(1); t++; end
        chk("ready_after_tx_done", {31'd0, ready}, 32'd1);
        tx_data = 16'h0F0F; start = 1'b1; tick_n(1); start = 1'b0;
        chk("launch_after_tiempo", {30'd0, cs_n, cnt_clr}, 32'b01);
        wait_rxv();
        chk("early_mosi_word", {16'd0, f_mosi}, 32'h0F0F);
        chk("early_rx_data", {16'd0, f_rx}, 32'h0F0F);
        wait_idle(200);

        // Pending word with directly driven tx_done/tiempo; second start while pending is dropped.
        ovr = 1'b1;
        tx_data = 16'hC0DE; start = 1'b1; tick_n(1); start = 1'b0;
        wait_rxv();
        tick_n(5);
        chk("gap_hold_state", {29'd0, busy, cnt_en, ready}, 32'b110);
        ovr_td = 1'b1; tick_n(1); ovr_td = 1'b0;
        chk("ready_on_tx_done", {31'd0, ready}, 32'd1);
        tx_data = 16'hBEEF; start = 1'b1; tick_n(1); start = 1'b0;
        chk("ready_low_when_pending", {31'd0, ready}, 32'd0);
        tx_data = 16'hDEAD; start = 1'b1; tick_n(1); start = 1'b0;
        tx_data = 16'h0000;
        tick_n(3);
        chk("pending_waits", {30'd0, cs_n, busy}, 32'b11);
        ovr_tm = 1'b1; tick_n(1); ovr_tm = 1'b0;
        chk("pending_launch", {29'd0, cs_n, cnt_clr, cnt_en}, 32'b010);
        wait_rxv();
        chk("pending_mosi_word", {16'd0, f_mosi}, 32'hBEEF);
        tick_n(3);
        ovr_tm = 1'b1; tick_n(1); ovr_tm = 1'b0;
        chk("tiempo_no_tx_done_exit", {29'd0, busy, cnt_en, ready}, 32'b001);
        ovr = 1'b0;

        // Reset in the middle of SHIFT after bit 7.
        tx_data = 16'hA5A5; start = 1'b1; tick_n(1); start = 1'b0;
        t = 0;
        while (f_falls < 8 && t < 300) begin tick_n(1); t++; end
        tick_n(1);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", {27'd0, cs_n, sclk, cnt_en, busy, rx_valid}, 32'b10000);
        tick_n(2);
        rst = 1'b0;
        tick_n(5);
        chk("no_rx_valid_after_abort", f_rxv, 0);
        run_frame(16'h3C3C, 1'b1, 16'h0000, 16'h3C3C);

        // start held high: one frame per gap, fixed period, no cs_n overlap.
        term = 30; loop = 1'b1;
        tx_data = 16'h6A6A; start = 1'b1;
        falls = 0; first_fall = 0; second_fall = 0; rxv_cnt = 0; pcs = cs_n; t = 0;
        while (falls < 3 && t < 2000) begin
            tick_n(1); t++;
            if (pcs && !cs_n) begin
                falls++;
                if (falls == 1) first_fall = t;
                if (falls == 2) second_fall = t;
            end
            if (falls >= 1 && rx_valid) rxv_cnt++;
            pcs = cs_n;
        end
        start = 1'b0;
        chk("b2b_frames_started", falls, 3);
        chk("b2b_period", t - second_fall, FRAME_CLKS + term);
        chk("b2b_first_period", second_fall - first_fall, FRAME_CLKS + term);
        chk("b2b_rx_valid_count", rxv_cnt, 2);
        wait_rxv();
        chk("b2b_mosi_word", {16'd0, f_mosi}, 32'h6A6A);
        wait_idle(500);

        // Random frames against the rule-based model.
        for (int i = 0; i < 8; i++) begin
            w    = DW'($urandom);
            sw   = DW'($urandom);
            lp   = 1'($urandom);
            term = $urandom_range(20, 60);
            tick_n($urandom_range(0, 5));
            run_frame(w, lp, sw, lp ? w : sw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
